ram_copy_engine: RTL



---
 rtl/ram_copy_if.sv | 29 ++
 rtl/ram_copy_engine.sv | 113 +++++++++++
 2 files changed

// File: rtl/ram_copy_if.sv
// Bundle of the copy-engine control port and the RAM load/address/data port.
// The slave modport is the engine's view; the master modport is the view of
// whoever issues the copy and supplies RAM read data.
interface ram_copy_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] mem_out;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [ADDR_W-1:0] mem_address;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;

  modport slave (
    input  start, src, dst, len, mem_out,
    output mem_in, mem_load, mem_address, busy, done, count
  );

  modport master (
    output start, src, dst, len, mem_out,
    input  mem_in, mem_load, mem_address, busy, done, count
  );
endinterface

// File: rtl/ram_copy_engine.sv
// Block-copy initiator for the 16K-word RAM: one read cycle then one write
// cycle per word, ascending addresses with wrap, one-cycle done pulse.
module ram_copy_engine #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  ram_copy_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LEN_ZERO = '0;
  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sptr_q, sptr_d;
  logic [ADDR_W-1:0] dptr_q, dptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dreg_q, dreg_d;

  // Next-state, pointer and RAM-port register computation.
  always_comb begin
    // NOTE: every _d starts as its _q so no branch can leave a latch behind.
    state_d = state_q;
    sptr_d  = sptr_q;
    dptr_d  = dptr_q;
    rem_d   = rem_q;
    count_d = count_q;
    addr_d  = addr_q;
    dreg_d  = dreg_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sptr_d  = bus.src;
          dptr_d  = bus.dst;
          rem_d   = bus.len;
          count_d = '0;
          if (bus.len == LEN_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            addr_d  = bus.src;
          end
        end
      end
      S_READ: begin
        // The word at sptr is on mem_out now; it becomes the write data.
        dreg_d  = bus.mem_out;
        addr_d  = dptr_q;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Pointers wrap naturally at the ADDR_W boundary.
        sptr_d  = sptr_q + 1'b1;
        dptr_d  = dptr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        count_d = count_q + 1'b1;
        if (rem_q == LEN_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          addr_d  = sptr_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any copy immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sptr_q  <= '0;
      dptr_q  <= '0;
      rem_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      dreg_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state_q <= state_d;
      sptr_q  <= sptr_d;
      dptr_q  <= dptr_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      dreg_q  <= dreg_d;
    end
  end

  // Outputs decode the registered state only, so mem_load cannot glitch.
  assign bus.mem_load    = (state_q == S_WRITE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.mem_address = addr_q;
  assign bus.mem_in      = dreg_q;
  assign bus.count       = count_q;

endmodule
